pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the ADC clock PLL wrapper, in the 50 MHz board-clock domain.
- Drives the PLL's active-high reset and qualifies its asynchronous `locked` output through a synchronizer and a stability window.
- Releases one active-low reset per PLL output clock domain in a staggered order.
- Re-arms automatically on lock loss, lock timeout or software request.

Parameters:
- NUM_DOMAINS, 6, number of downstream domain resets (one per PLL outclk)
- RST_CYCLES, 16, cycles pll_rst is held high per reset attempt
- LOCK_TIMEOUT, 50000, cycles to wait for lock before retrying (1 ms at 50 MHz)
- STABLE_CYCLES, 1024, consecutive synced-locked cycles required before release
- RELEASE_GAP, 8, cycles between successive domain reset releases
- SYNC_STAGES, 2, flip-flop stages on pll_locked (minimum 2)

Ports:
- clk  in  1  50 MHz board clock (same source as the PLL refclk)
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL locked output, asynchronous to clk
- soft_reset  in  1  single-cycle request to re-run the full sequence
- pll_rst  out  1  active-high reset to the PLL
- dom_rst_n  out  NUM_DOMAINS  per-domain active-low resets; bit i is released i-th
- ready  out  1  high when all domains are released and lock is held
- state  out  3  current FSM state encoding, for status/debug
- retry_count  out  8  saturating count of lock-timeout retries
- lock_loss_count  out  16  lock-loss event count (see Optional Feature)

Behaviour:
- Reset: one clock; rst_n is asynchronous assert, active-low. While rst_n is low:
  - pll_rst=1, dom_rst_n=all 0, ready=0, state=PLL_RST
  - retry_count=0, lock_loss_count=0, all counters 0, synchronizer flops 0
- Synchronizer: pll_locked passes through SYNC_STAGES flops to give `lk`. Every FSM decision uses only `lk`.
- FSM states and encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RELEASE=3, RUN=4.
- PLL_RST:
  - pll_rst=1, dom_rst_n=0.
  - Exactly RST_CYCLES cycles, counted from the first clock after rst_n rises, then go to WAIT_LOCK. pll_rst falls on that transition.
- WAIT_LOCK:
  - lk=1 -> STABLE, stability counter cleared.
  - LOCK_TIMEOUT cycles elapse without lk -> PLL_RST, retry_count increments, saturating at 255.
- STABLE:
  - Counter increments while lk=1.
  - lk=0 -> WAIT_LOCK, timeout counter restarts.
  - Counter reaches STABLE_CYCLES-1 with lk=1 -> RELEASE.
- RELEASE:
  - dom_rst_n[0] goes high on entry.
  - dom_rst_n[i] goes high RELEASE_GAP cycles after bit i-1.
  - After the last bit goes high, go to RUN on the next cycle.
  - lk=0 at any point -> all dom_rst_n low on the next edge, then PLL_RST.
- RUN:
  - ready=1.
  - lk=0 -> ready=0 and all dom_rst_n=0 on the next edge, then PLL_RST. lock_loss_count increments.
- soft_reset:
  - In any state, a high on soft_reset forces PLL_RST on the next edge, with all dom_rst_n=0 and ready=0.
  - Neither retry_count nor lock_loss_count changes.
  - If soft_reset and lk falling coincide in RUN, soft_reset wins and lock_loss_count does not increment.
- ready is registered. It is high only in RUN and falls in the same edge as dom_rst_n.
- Counters:
  - Width is $clog2 of the largest of LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES.
  - A single shared counter is reused per state and cleared on every state transition.
- Glitch immunity: an lk low pulse of a single cycle in STABLE restarts qualification. Lock chatter never releases any domain reset.

Optional Feature:
- Macro LOCK_LOSS_COUNTER_EN.
- Defined: lock_loss_count is a 16-bit counter that increments on each RUN->PLL_RST transition caused by lk=0, saturating at 16'hFFFF and cleared only by rst_n.
- Not defined: lock_loss_count is tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package clk_rst_pkg holds:
  - the state enum seq_state_t with the encodings above
  - localparam SEQ_STATE_W=3
- One sub-module, bit_synchronizer: parameterised depth, with asynchronous active-low reset to 0. It is reused for pll_locked and reusable elsewhere in the design.

Test Plan:
- Clean lock: rst_n released, pll_locked rises 100 cycles later and stays high.
  - pll_rst falls at cycle 16.
  - dom_rst_n[0] rises SYNC_STAGES+1024 cycles after the lock edge, then each further bit 8 cycles apart.
  - ready=1 one cycle after dom_rst_n[5].
- Timeout: pll_locked held 0.
  - PLL_RST is re-entered every 16+50000 cycles.
  - retry_count reads 1, 2, 3.
  - Forcing 300 retries (with LOCK_TIMEOUT=10) saturates retry_count at 255.
- Chatter: pll_locked toggles high for 500 cycles and low for 1 cycle, repeatedly.
  - dom_rst_n stays 0 throughout.
  - The FSM alternates only between WAIT_LOCK and STABLE.
- Lock loss in RUN: drop pll_locked.
  - dom_rst_n=0 and ready=0 at the SYNC_STAGES+1 edge.
  - pll_rst=1 on the next cycle.
  - lock_loss_count=1 with LOCK_LOSS_COUNTER_EN, 0 without.
- Mid-sequence disturbances:
  - soft_reset pulse in RELEASE after 3 bits are released -> all dom_rst_n=0 next edge, full sequence re-runs, counters unchanged.
  - rst_n asserted mid-RUN -> all outputs take reset values asynchronously.

Source files
------------

// File: rtl/clk_rst_pkg.sv
// Shared clock/reset-sequencing types.
// Holds the sequencer state encoding (also exported on the status port),
// its width and a small helper for sizing shared counters.
package clk_rst_pkg;

    localparam int unsigned SEQ_STATE_W = 3;

    // Encodings are visible to software through the state status port.
    typedef enum logic [SEQ_STATE_W-1:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } seq_state_t;

    // Largest of three cycle counts; used to size a counter shared between states.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_if.sv
// PLL-side and status signals of the PLL reset sequencer.
//   pll_locked      : PLL lock indication, asynchronous to clk
//   soft_reset      : single-cycle request to re-run the whole sequence
//   pll_rst         : active-high PLL reset
//   dom_rst_n       : per-domain active-low resets, bit i released i-th
//   ready           : all domains released and lock held
//   state           : sequencer state encoding (status/debug)
//   retry_count     : saturating lock-timeout retry count
//   lock_loss_count : lock-loss event count (zero unless the counter is built)
// Modport master is the sequencer; slave is the PLL wrapper / status consumer.
interface pll_reset_sequencer_if #(
    parameter int unsigned NUM_DOMAINS = 6
);

    logic                                 pll_locked;
    logic                                 soft_reset;
    logic                                 pll_rst;
    logic [NUM_DOMAINS-1:0]               dom_rst_n;
    logic                                 ready;
    logic [clk_rst_pkg::SEQ_STATE_W-1:0]  state;
    logic [7:0]                           retry_count;
    logic [15:0]                          lock_loss_count;

    modport master (
        input  pll_locked,
        input  soft_reset,
        output pll_rst,
        output dom_rst_n,
        output ready,
        output state,
        output retry_count,
        output lock_loss_count
    );

    modport slave (
        output pll_locked,
        output soft_reset,
        input  pll_rst,
        input  dom_rst_n,
        input  ready,
        input  state,
        input  retry_count,
        input  lock_loss_count
    );

endinterface

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d     : asynchronous input
//   q     : synchronized output, STAGES clocks of latency
// Depths below 2 are raised to 2 so a metastability stage always exists.
module bit_synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    localparam int unsigned DEPTH = (STAGES < 2) ? 2 : STAGES;

    logic [DEPTH-1:0] sync_q;

    // Shift chain; bit 0 is the metastability-catching stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[DEPTH-2:0], d};
        end
    end

    assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer for the ADC clock PLL, board-clock domain.
// Holds the PLL in reset, waits for a synchronized and stable lock, then
// releases one active-low reset per PLL output domain in a staggered order.
// Re-arms on lock timeout, on lock loss and on a software request.
//   clk   : 50 MHz board clock (PLL reference)
//   rst_n : asynchronous active-low reset
//   bus   : pll_reset_sequencer_if.master (PLL lock/reset, domain resets, status)
// Build option: define LOCK_LOSS_COUNTER_EN to implement the 16-bit
// saturating lock-loss counter; otherwise lock_loss_count is tied to zero.
module pll_reset_sequencer
    import clk_rst_pkg::*;
#(
    parameter int unsigned NUM_DOMAINS   = 6,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 50000,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned RELEASE_GAP   = 8,
    parameter int unsigned SYNC_STAGES   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pll_reset_sequencer_if.master  bus
);

    localparam int unsigned CNT_MAX = max3(LOCK_TIMEOUT, STABLE_CYCLES, RST_CYCLES);
    localparam int unsigned CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(RELEASE_GAP - 1);

    seq_state_t              state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    pll_rst_q;
    logic [NUM_DOMAINS-1:0]  dom_q;
    logic                    ready_q;
    logic [7:0]              retry_q;
    logic                    abort_q;
    logic                    lk;

    // Lock indication brought into clk; all decisions below use lk only.
    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (lk)
    );

    // Sequencer. abort_q marks the one cycle between dropping the domain
    // resets on lock loss and re-entering PLL_RST, so domains are held in
    // reset before the PLL itself is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
            retry_q   <= '0;
            abort_q   <= 1'b0;
        end else if (bus.soft_reset) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_q     <= '0;
            ready_q   <= 1'b0;
            abort_q   <= 1'b0;
        end else if (abort_q) begin
            state_q   <= PLL_RST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            abort_q   <= 1'b0;
        end else begin
            case (state_q)
                PLL_RST: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                WAIT_LOCK: begin
                    if (lk) begin
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_q   <= PLL_RST;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q != 8'hFF) begin
                            retry_q <= retry_q + 8'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // Any single low cycle of lk restarts qualification.
                STABLE: begin
                    if (!lk) begin
                        state_q <= WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_q <= RELEASE;
                        cnt_q   <= '0;
                        dom_q   <= NUM_DOMAINS'(1);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                // dom_q fills from bit 0 upward; the top bit set means all released.
                RELEASE: begin
                    if (!lk) begin
                        abort_q <= 1'b1;
                        dom_q   <= '0;
                        cnt_q   <= '0;
                    end else if (dom_q[NUM_DOMAINS-1]) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else if (cnt_q == GAP_LAST) begin
                        dom_q <= (dom_q << 1) | NUM_DOMAINS'(1);
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                RUN: begin
                    if (!lk) begin
                        abort_q <= 1'b1;
                        dom_q   <= '0;
                        ready_q <= 1'b0;
                    end
                end

                default: begin
                    state_q   <= PLL_RST;
                    cnt_q     <= '0;
                    pll_rst_q <= 1'b1;
                    dom_q     <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef LOCK_LOSS_COUNTER_EN
    logic [15:0] lock_loss_q;

    // Counts RUN exits caused by lock loss; a coincident soft_reset suppresses it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_q <= '0;
        end else if (abort_q && !bus.soft_reset && (state_q == RUN)
                     && (lock_loss_q != 16'hFFFF)) begin
            lock_loss_q <= lock_loss_q + 16'd1;
        end
    end

    assign bus.lock_loss_count = lock_loss_q;
`else
    assign bus.lock_loss_count = '0;
`endif

    assign bus.pll_rst     = pll_rst_q;
    assign bus.dom_rst_n   = dom_q;
    assign bus.ready       = ready_q;
    assign bus.state       = state_q;
    assign bus.retry_count = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a phase/elapsed-time model checked every
// cycle on dut_a, directed literal checks at hand-computed cycle numbers,
// and a second instance (dut_b, short lock timeout) for retry saturation.
module tb_pll_reset_sequencer;

    localparam int unsigned ND   = 6;
    localparam int unsigned RSTC = 16;
    localparam int unsigned LT   = 300;
    localparam int unsigned SC   = 64;
    localparam int unsigned GAP  = 8;
    localparam int unsigned SS   = 2;

`ifdef LOCK_LOSS_COUNTER_EN
    localparam int unsigned EXP_LL = 1;
`else
    localparam int unsigned EXP_LL = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_b_n;

    pll_reset_sequencer_if #(.NUM_DOMAINS(ND)) pif_a ();
    pll_reset_sequencer_if #(.NUM_DOMAINS(ND)) pif_b ();

    pll_reset_sequencer #(
        .NUM_DOMAINS(ND), .RST_CYCLES(RSTC), .LOCK_TIMEOUT(LT),
        .STABLE_CYCLES(SC), .RELEASE_GAP(GAP), .SYNC_STAGES(SS)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(pif_a)
    );

    pll_reset_sequencer #(
        .NUM_DOMAINS(ND), .RST_CYCLES(16), .LOCK_TIMEOUT(10),
        .STABLE_CYCLES(4), .RELEASE_GAP(8), .SYNC_STAGES(2)
    ) dut_b (
        .clk(clk), .rst_n(rst_b_n), .bus(pif_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Edge counters since the respective reset release.
    int unsigned ecnt, ecnt_b;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) ecnt <= 0; else ecnt <= ecnt + 1;
    always @(posedge clk or negedge rst_b_n)
        if (!rst_b_n) ecnt_b <= 0; else ecnt_b <= ecnt_b + 1;

    // ---------------- behavioural model of dut_a ----------------
    typedef enum {M_RST, M_WAIT, M_QUAL, M_REL, M_RUN, M_DROP} mphase_t;
    mphase_t     ph;
    int unsigned n, t0;
    bit          hist[$];
    bit          drop_from_run;
    int unsigned m_retry, m_loss;

    always @(posedge clk or negedge rst_n) begin : model_step
        bit          lkp;
        bit          mv;
        int unsigned e;
        mphase_t     nx;
        if (!rst_n) begin
            ph = M_RST; n = 0; t0 = 0; hist.delete();
            m_retry = 0; m_loss = 0; drop_from_run = 0;
        end else begin
            n++;
            e   = n - t0;
            // lock as seen by the sequencer: the sample taken SS edges ago
            lkp = (hist.size() == SS) ? hist[0] : 1'b0;
            hist.push_back(pif_a.pll_locked);
            if (hist.size() > SS) void'(hist.pop_front());
            nx = ph; mv = 0;
            if (pif_a.soft_reset) begin
                nx = M_RST; mv = 1;
            end else begin
                case (ph)
                    M_DROP: begin
                        if (drop_from_run && m_loss < 65535 && EXP_LL == 1) m_loss++;
                        nx = M_RST; mv = 1;
                    end
                    M_RST:  if (e == RSTC) begin nx = M_WAIT; mv = 1; end
                    M_WAIT: if (lkp) begin nx = M_QUAL; mv = 1; end
                            else if (e == LT) begin
                                if (m_retry < 255) m_retry++;
                                nx = M_RST; mv = 1;
                            end
                    M_QUAL: if (!lkp) begin nx = M_WAIT; mv = 1; end
                            else if (e == SC) begin nx = M_REL; mv = 1; end
                    M_REL:  if (!lkp) begin drop_from_run = 0; nx = M_DROP; mv = 1; end
                            else if (e == GAP*(ND-1)+1) begin nx = M_RUN; mv = 1; end
                    M_RUN:  if (!lkp) begin drop_from_run = 1; nx = M_DROP; mv = 1; end
                    default: ;
                endcase
            end
            if (mv) begin ph = nx; t0 = n; end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin : model_cmp
        logic [ND-1:0] md;
        int unsigned   k;
        int unsigned   code;
        if (rst_n) begin
            md = '0;
            if (ph == M_RUN) md = '1;
            else if (ph == M_REL) begin
                k = (n - t0) / GAP + 1;
                for (int i = 0; i < ND; i++) if (i < k) md[i] = 1'b1;
            end
            case (ph)
                M_RST:   code = 0;
                M_WAIT:  code = 1;
                M_QUAL:  code = 2;
                M_REL:   code = 3;
                M_RUN:   code = 4;
                default: code = drop_from_run ? 4 : 3;
            endcase
            check("model_pll_rst",   32'(pif_a.pll_rst),         32'(ph == M_RST));
            check("model_dom_rst_n", 32'(pif_a.dom_rst_n),       32'(md));
            check("model_ready",     32'(pif_a.ready),           32'(ph == M_RUN));
            check("model_state",     32'(pif_a.state),           code);
            check("model_retry",     32'(pif_a.retry_count),     m_retry);
            check("model_lock_loss", 32'(pif_a.lock_loss_count), m_loss);
        end
    end

    // Chatter monitor.
    bit          chat_en = 0;
    int unsigned chat_bad = 0, qual_entries = 0;
    logic [2:0]  prev_state = 3'd0;
    always @(negedge clk) begin
        if (chat_en && rst_n && ecnt >= 16) begin
            if (pif_a.dom_rst_n != '0 || !(pif_a.state == 3'd1 || pif_a.state == 3'd2))
                chat_bad++;
            if (pif_a.state == 3'd2 && prev_state == 3'd1) qual_entries++;
        end
        prev_state = pif_a.state;
    end

    task automatic wait_ecnt(input int unsigned k);
        while (ecnt != k) @(negedge clk);
    endtask

    // ---------------- dut_b: retry saturation ----------------
    bit b_done = 0;
    initial begin
        rst_b_n = 1'b0;
        pif_b.pll_locked = 1'b0;
        pif_b.soft_reset = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_b_n = 1'b1;
        while (ecnt_b != 77) @(negedge clk);
        check("b_retry_77", 32'(pif_b.retry_count), 2);
        while (ecnt_b != 78) @(negedge clk);
        check("b_retry_78", 32'(pif_b.retry_count), 3);
        while (ecnt_b != 6629) @(negedge clk);
        check("b_retry_254", 32'(pif_b.retry_count), 254);
        while (ecnt_b != 6630) @(negedge clk);
        check("b_retry_255", 32'(pif_b.retry_count), 255);
        while (ecnt_b != 7800) @(negedge clk);
        check("b_retry_sat", 32'(pif_b.retry_count), 255);
        check("b_state_rst", 32'(pif_b.state), 0);
        while (ecnt_b != 7816) @(negedge clk);
        check("b_state_wait", 32'(pif_b.state), 1);
        check("b_pll_rst_low", 32'(pif_b.pll_rst), 0);
        b_done = 1;
    end

    // ---------------- dut_a directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        pif_a.pll_locked = 1'b0;
        pif_a.soft_reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pll_rst",   32'(pif_a.pll_rst), 1);
        check("rst_dom",       32'(pif_a.dom_rst_n), 0);
        check("rst_ready",     32'(pif_a.ready), 0);
        check("rst_state",     32'(pif_a.state), 0);
        check("rst_retry",     32'(pif_a.retry_count), 0);
        check("rst_lock_loss", 32'(pif_a.lock_loss_count), 0);
        #1 rst_n = 1'b1;

        // Clean lock; pll_locked first sampled at edge 100.
        wait_ecnt(15);  check("pll_rst_15", 32'(pif_a.pll_rst), 1);
        wait_ecnt(16);  check("pll_rst_16", 32'(pif_a.pll_rst), 0);
                        check("state_16", 32'(pif_a.state), 1);
        wait_ecnt(99);  pif_a.pll_locked = 1'b1;
        wait_ecnt(165); check("dom_165", 32'(pif_a.dom_rst_n), 0);
        wait_ecnt(166); check("dom_166", 32'(pif_a.dom_rst_n), 1);
                        check("state_166", 32'(pif_a.state), 3);
        wait_ecnt(174); check("dom_174", 32'(pif_a.dom_rst_n), 3);
        wait_ecnt(206); check("dom_206", 32'(pif_a.dom_rst_n), 63);
                        check("ready_206", 32'(pif_a.ready), 0);
        wait_ecnt(207); check("ready_207", 32'(pif_a.ready), 1);
                        check("state_207", 32'(pif_a.state), 4);

        // Lock loss in RUN; drop first sampled at edge 251.
        wait_ecnt(250); pif_a.pll_locked = 1'b0;
        wait_ecnt(252); check("dom_252", 32'(pif_a.dom_rst_n), 63);
        wait_ecnt(253); check("dom_253", 32'(pif_a.dom_rst_n), 0);
                        check("ready_253", 32'(pif_a.ready), 0);
                        check("pll_rst_253", 32'(pif_a.pll_rst), 0);
        wait_ecnt(254); check("pll_rst_254", 32'(pif_a.pll_rst), 1);
                        check("state_254", 32'(pif_a.state), 0);
                        check("lock_loss_254", 32'(pif_a.lock_loss_count), EXP_LL);

        // Re-lock, then soft_reset after three domains are released.
        wait_ecnt(260); pif_a.pll_locked = 1'b1;
        wait_ecnt(355); check("dom_355", 32'(pif_a.dom_rst_n), 7);
                        pif_a.soft_reset = 1'b1;
        wait_ecnt(356); pif_a.soft_reset = 1'b0;
                        check("soft_dom", 32'(pif_a.dom_rst_n), 0);
                        check("soft_state", 32'(pif_a.state), 0);
                        check("soft_pll_rst", 32'(pif_a.pll_rst), 1);
                        check("soft_retry", 32'(pif_a.retry_count), 0);
                        check("soft_lock_loss", 32'(pif_a.lock_loss_count), EXP_LL);
        wait_ecnt(477); check("ready_477", 32'(pif_a.ready), 0);
        wait_ecnt(478); check("ready_478", 32'(pif_a.ready), 1);

        // Asynchronous reset mid-RUN.
        wait_ecnt(490);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("arst_pll_rst",   32'(pif_a.pll_rst), 1);
        check("arst_dom",       32'(pif_a.dom_rst_n), 0);
        check("arst_ready",     32'(pif_a.ready), 0);
        check("arst_state",     32'(pif_a.state), 0);
        check("arst_lock_loss", 32'(pif_a.lock_loss_count), 0);

        // Lock timeout with pll_locked held low.
        pif_a.pll_locked = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        wait_ecnt(315); check("retry_315", 32'(pif_a.retry_count), 0);
                        check("state_315", 32'(pif_a.state), 1);
        wait_ecnt(316); check("retry_316", 32'(pif_a.retry_count), 1);
                        check("state_316", 32'(pif_a.state), 0);
                        check("pll_rst_316", 32'(pif_a.pll_rst), 1);
        wait_ecnt(632); check("retry_632", 32'(pif_a.retry_count), 2);
        wait_ecnt(948); check("retry_948", 32'(pif_a.retry_count), 3);

        // Lock chatter: 40 cycles high, 1 cycle low, repeated.
        @(negedge clk); #1 rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
        chat_en = 1;
        for (int p = 0; p < 20; p++) begin
            pif_a.pll_locked = 1'b1;
            repeat (40) @(negedge clk);
            pif_a.pll_locked = 1'b0;
            @(negedge clk);
        end
        pif_a.pll_locked = 1'b1;
        chat_en = 0;
        check("chatter_violations", chat_bad, 0);
        check("chatter_qual_seen", 32'(qual_entries >= 15), 1);

        // Reach RUN, then soft_reset coinciding with the sequencer seeing lock loss.
        for (int i = 0; i < 400 && !pif_a.ready; i++) @(negedge clk);
        check("ready_after_chatter", 32'(pif_a.ready), 1);
        pif_a.pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        pif_a.soft_reset = 1'b1;
        @(negedge clk);
        pif_a.soft_reset = 1'b0;
        check("coinc_state", 32'(pif_a.state), 0);
        check("coinc_pll_rst", 32'(pif_a.pll_rst), 1);
        check("coinc_dom", 32'(pif_a.dom_rst_n), 0);
        repeat (5) @(negedge clk);
        check("coinc_lock_loss", 32'(pif_a.lock_loss_count), 0);

        for (int i = 0; i < 10000 && !b_done; i++) @(negedge clk);
        check("dut_b_done", 32'(b_done), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
